// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream and
// writes it into a 16x16 instruction memory while holding the CPU.
module imem_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  fetch_addr,
  output logic [15:0] fetch_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        error,
  output logic [4:0]  word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  len_q, len_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  csum_q, csum_d;
  logic [3:0]  addr_q, addr_d;
  logic [4:0]  word_count_q, word_count_d;
  logic [15:0] fetch_data_q, fetch_data_d;
  logic        in_ready_q, in_ready_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        load_done_q, load_done_d;
  logic        error_q, error_d;
  logic [15:0] mem_q [16];

  logic accept;
  logic restart;
  logic last_word;
  logic mem_we;

  assign accept    = in_valid && in_ready_q;
  assign restart   = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign last_word = (5'(word_count_q + 5'd1) == len_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      hi_q         <= '0;
      csum_q       <= '0;
      addr_q       <= '0;
      word_count_q <= '0;
      fetch_data_q <= '0;
      in_ready_q   <= 1'b0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      hi_q         <= hi_d;
      csum_q       <= csum_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      fetch_data_q <= fetch_data_d;
      in_ready_q   <= in_ready_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      error_q      <= error_d;
    end
  end

  // Memory survives reset so a partially loaded program stays readable.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= {hi_q, in_data};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN;
      S_LEN: if (accept) state_d = (in_data == 8'd0 || in_data > 8'd16) ? S_ERR : S_HI;
      S_HI:  if (accept) state_d = S_LO;
      S_LO:  if (accept) state_d = last_word ? S_CSUM : S_HI;
      S_CSUM: if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    len_d        = len_q;
    hi_d         = hi_q;
    csum_d       = csum_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    mem_we       = 1'b0;
    fetch_data_d = mem_q[fetch_addr];
    if (restart) begin
      csum_d       = '0;
      addr_d       = '0;
      word_count_d = '0;
    end else if (accept) begin
      case (state_q)
        S_LEN: len_d = in_data[4:0];
        S_HI: begin
          hi_d   = in_data;
          csum_d = csum_q ^ in_data;
        end
        S_LO: begin
          csum_d       = csum_q ^ in_data;
          addr_d       = addr_q + 4'd1;
          word_count_d = word_count_q + 5'd1;
          mem_we       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    in_ready_d  = (state_d == S_LEN) || (state_d == S_HI) ||
                  (state_d == S_LO)  || (state_d == S_CSUM);
    cpu_hold_d  = (state_d != S_DONE);
    load_done_d = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
  end

  assign in_ready   = in_ready_q;
  assign fetch_data = fetch_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed loads, a vector table and random loads,
// all checked against a simple array model of the instruction memory.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  fetch_addr;
  logic [15:0] fetch_data;
  logic        cpu_hold;
  logic        load_done;
  logic        error;
  logic [4:0]  word_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] model_mem [16];

  typedef struct {
    logic [7:0] len;
    bit         bad;
    int         gap;
    bit         exp_done;
    bit         exp_err;
    int         exp_wc;
  } vec_t;

  vec_t vecs [8];

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // All stimulus tasks start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check_output("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [7:0] len, input bit bad, input int gap);
    logic [7:0] hi, lo, csum;
    pulse_start();
    send_byte(len, gap);
    if (len >= 8'd1 && len <= 8'd16) begin
      csum = 8'h00;
      for (int k = 0; k < int'(len); k++) begin
        hi = 8'($urandom);
        lo = 8'($urandom);
        send_byte(hi, gap);
        send_byte(lo, gap);
        model_mem[k] = {hi, lo};
        csum = csum ^ hi ^ lo;
      end
      send_byte(bad ? (csum ^ 8'h3C) : csum, gap);
    end
  endtask

  task automatic check_result(input string tag, input bit done, input bit err, input int wc);
    check_output({tag, ".load_done"}, {31'd0, load_done}, {31'd0, done});
    check_output({tag, ".error"}, {31'd0, error}, {31'd0, err});
    check_output({tag, ".cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !done});
    check_output({tag, ".in_ready"}, {31'd0, in_ready}, 32'd0);
    check_output({tag, ".word_count"}, {27'd0, word_count}, wc);
  endtask

  task automatic check_fetch(input string tag, input int a);
    fetch_addr = 4'(a);
    @(negedge clk);
    check_output($sformatf("%s.fetch[%0d]", tag, a), {16'd0, fetch_data}, {16'd0, model_mem[a]});
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, ".in_ready"}, {31'd0, in_ready}, 32'd0);
    check_output({tag, ".cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    check_output({tag, ".load_done"}, {31'd0, load_done}, 32'd0);
    check_output({tag, ".error"}, {31'd0, error}, 32'd0);
    check_output({tag, ".word_count"}, {27'd0, word_count}, 32'd0);
    check_output({tag, ".fetch_data"}, {16'd0, fetch_data}, 32'd0);
  endtask

  initial begin
    logic [7:0] rlen;
    bit         rbad;
    bit         rok;
    logic [7:0] seq033 [6];
    logic [7:0] seq034 [4];

    vecs[0] = '{8'h10, 1'b0, 0, 1'b1, 1'b0, 16};
    vecs[1] = '{8'h02, 1'b0, 0, 1'b1, 1'b0, 2};
    vecs[2] = '{8'h10, 1'b0, 1, 1'b1, 1'b0, 16};
    vecs[3] = '{8'h00, 1'b0, 0, 1'b0, 1'b1, 0};
    vecs[4] = '{8'h11, 1'b0, 0, 1'b0, 1'b1, 0};
    vecs[5] = '{8'h01, 1'b1, 0, 1'b0, 1'b1, 1};
    vecs[6] = '{8'h07, 1'b1, 2, 1'b0, 1'b1, 7};
    vecs[7] = '{8'hFF, 1'b0, 0, 1'b0, 1'b1, 0};
    seq033 = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    seq034 = '{8'h01, 8'h00, 8'hFF, 8'h00};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; fetch_addr = 4'd0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);
    check_output("idle.in_ready", {31'd0, in_ready}, 32'd0);
    check_output("idle.cpu_hold", {31'd0, cpu_hold}, 32'd1);

    $display("[TB] known-good two-word load");
    pulse_start();
    check_output("len.in_ready", {31'd0, in_ready}, 32'd1);
    foreach (seq033[i]) send_byte(seq033[i], 0);
    model_mem[0] = 16'h1234;
    model_mem[1] = 16'hABCD;
    check_result("load2", 1'b1, 1'b0, 2);
    check_fetch("load2", 1);
    check_fetch("load2", 0);

    $display("[TB] bad checksum load");
    pulse_start();
    foreach (seq034[i]) send_byte(seq034[i], 0);
    model_mem[0] = 16'h00FF;
    check_result("badcsum", 1'b0, 1'b1, 1);
    check_fetch("badcsum", 0);
    check_fetch("badcsum", 1);

    $display("[TB] vector table");
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].len, vecs[i].bad, vecs[i].gap);
      check_result($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_wc);
      for (int a = 0; a < 16; a++) check_fetch($sformatf("vec%0d", i), a);
    end

    $display("[TB] ignored start and reset mid-load");
    pulse_start();
    send_byte(8'h05, 0);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] hi, lo;
      hi = 8'($urandom);
      lo = 8'($urandom);
      send_byte(hi, 0);
      send_byte(lo, 0);
      model_mem[k] = {hi, lo};
    end
    send_byte(8'h5A, 0);
    pulse_start();
    check_output("lo_start.in_ready", {31'd0, in_ready}, 32'd1);
    check_output("lo_start.word_count", {27'd0, word_count}, 32'd3);
    #2 reset = 1'b1;
    #1 check_reset_values("midreset");
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 3; a++) check_fetch("midreset", a);
    apply_stimulus(8'h03, 1'b0, 0);
    check_result("after_reset", 1'b1, 1'b0, 3);
    for (int a = 0; a < 16; a++) check_fetch("after_reset", a);

    $display("[TB] random loads");
    for (int r = 0; r < 20; r++) begin
      rlen = 8'($urandom_range(0, 18));
      rbad = ($urandom_range(0, 3) == 0);
      rok  = (rlen >= 8'd1 && rlen <= 8'd16);
      apply_stimulus(rlen, rbad, $urandom_range(0, 2));
      check_result($sformatf("rand%0d", r), rok && !rbad, !(rok && !rbad), rok ? int'(rlen) : 0);
      for (int a = 0; a < 16; a++) check_fetch($sformatf("rand%0d", r), a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameters: none; instruction memory fixed at 16 words x 16 bits, 4-bit address.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle pulse; begins a new program load.
REQ-005 in_data  input  8  byte stream from host.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready.
REQ-008 fetch_addr  input  4  CPU instruction fetch address (program counter).
REQ-009 fetch_data  output  16  instruction at fetch_addr, registered.
REQ-010 cpu_hold  output  1  holds CPU program counter in reset while high.
REQ-011 load_done  output  1  program loaded and checksum correct.
REQ-012 error  output  1  last load aborted (bad length or checksum).
REQ-013 word_count  output  5  words written in current or last load, 0..16.

Function
REQ-014 FSM states: IDLE, LEN, HI, LO, CSUM, DONE, ERR; all outputs registered.
REQ-015 start in IDLE, DONE or ERR -> LEN next cycle; clears load_done, error, word_count, checksum, write address; start in LEN/HI/LO/CSUM ignored.
REQ-016 in_ready = 1 exactly in LEN, HI, LO, CSUM; 0 in IDLE, DONE, ERR.
REQ-017 Bytes with in_valid low ignored; state holds indefinitely awaiting valid (no timeout).
REQ-018 LEN: accepted byte N; N==0 or N>16 -> ERR; else store N, -> HI.
REQ-019 HI: accepted byte latched as high byte, XORed into checksum, -> LO.
REQ-020 LO: mem[addr] <= {high byte, in_data} on acceptance edge; byte XORed into checksum; addr and word_count increment; -> CSUM when this was word N, else HI.
REQ-021 Byte order: high byte first; word k (0-based) written to address k.
REQ-022 Checksum: 8-bit XOR of all 2N data bytes; length byte excluded.
REQ-023 CSUM: accepted byte equal to checksum -> DONE, else -> ERR.
REQ-024 DONE: load_done=1, cpu_hold=0, error=0; remains until start or reset.
REQ-025 ERR: error=1, load_done=0, cpu_hold=1; remains until start or reset.
REQ-026 cpu_hold=1 in every state except DONE.
REQ-027 fetch_data <= mem[fetch_addr] every cycle in all states (1-cycle latency); same-cycle write and read of one address returns old data.
REQ-028 Memory words beyond N retain prior contents; memory is not cleared by start.
REQ-029 word_count holds its final value in DONE and ERR.

Reset
REQ-030 reset: state IDLE, in_ready=0, cpu_hold=1, load_done=0, error=0, word_count=0, fetch_data=0, checksum=0, addr=0.
REQ-031 Memory array not reset; words written before a mid-load reset persist.
REQ-032 reset mid-load (any of LEN/HI/LO/CSUM) abandons the load; next start restarts from LEN.

Verification
REQ-033 reset, start, bytes 02,12,34,AB,CD,checksum 40 -> mem[0]=1234, mem[1]=ABCD, load_done=1, cpu_hold=0, word_count=2; fetch_addr=1 -> fetch_data=ABCD one cycle later.
REQ-034 start, bytes 01,00,FF, checksum 00 -> error=1, load_done=0, cpu_hold=1, word_count=1, mem[0]=00FF.
REQ-035 start, length byte 00 then separately 11 -> ERR after length byte, in_ready=0, word_count=0.
REQ-036 N=16 with in_valid toggling every other cycle -> all 16 words written, word_count=16, load_done=1, no byte lost or duplicated.
REQ-037 reset asserted after HI byte of word 3 -> all outputs at reset values immediately, words 0..2 readable via fetch_data; start pulse during LO ignored.
